// File: rtl/rs_pkg.sv
// Shared reservation-station types: entry layout and the wakeup tag-match helper.
package rs_pkg;

  localparam int PAYLOAD_WIDTH = 32;
  localparam int TAG_WIDTH     = 6;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic [TAG_WIDTH-1:0]     src1_tag;
    logic                     src1_rdy;
    logic [TAG_WIDTH-1:0]     src2_tag;
    logic                     src2_rdy;
  } rs_entry_t;

  // True when either broadcast bus carries a valid copy of tag.
  function automatic logic tag_hit(input logic [1:0]                wb_valid,
                                   input logic [1:0][TAG_WIDTH-1:0] wb_tag,
                                   input logic [TAG_WIDTH-1:0]      tag);
    return (wb_valid[0] && (wb_tag[0] == tag)) ||
           (wb_valid[1] && (wb_tag[1] == tag));
  endfunction

endpackage

// File: rtl/rs_pick2_ready.sv
// Lowest-two-index picker: slot 0 gets the lowest set bit, slot 1 the next one.
module rs_pick2_ready #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]       ready,
  output logic [1:0]         pick_valid,
  output logic [1:0][IW-1:0] pick_index
);

  always_comb begin
    pick_valid = '0;
    pick_index = '0;
    for (int i = 0; i < N; i++) begin
      if (ready[i]) begin
        if (!pick_valid[0]) begin
          pick_valid[0] = 1'b1;
          pick_index[0] = IW'(i);
        end else if (!pick_valid[1]) begin
          pick_valid[1] = 1'b1;
          pick_index[1] = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rs_issue2.sv
// Dual-write, dual-issue reservation station: entry storage, tag wakeup,
// and two-port issue selection over registered ready state.
module rs_issue2
  import rs_pkg::*;
#(
  parameter int RS_SIZE        = 4,
  parameter int RS_INDEX_WIDTH = $clog2(RS_SIZE)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [1:0]                          wr_valid_i,
  input  logic [1:0][RS_INDEX_WIDTH-1:0]      wr_index_i,
  input  rs_entry_t [1:0]                     wr_entry_i,
  input  logic [1:0]                          wb_valid_i,
  input  logic [1:0][TAG_WIDTH-1:0]           wb_tag_i,
  output logic [1:0]                          issue_valid_o,
  input  logic [1:0]                          issue_ready_i,
  output logic [1:0][PAYLOAD_WIDTH-1:0]       issue_payload_o,
  output logic [1:0][RS_INDEX_WIDTH-1:0]      issue_index_o,
  output logic [RS_SIZE-1:0]                  rs_unused_o,
  output logic                                rs_empty_o
);

  logic [RS_SIZE-1:0] valid_q;
  logic [RS_SIZE-1:0] valid_d;
  rs_entry_t          entry_q [RS_SIZE];
  rs_entry_t          entry_d [RS_SIZE];
  logic [RS_SIZE-1:0] ready_vec;
  logic [1:0]         fire;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = valid_q[i] & entry_q[i].src1_rdy & entry_q[i].src2_rdy;
    end
  end

  rs_pick2_ready #(
    .N  (RS_SIZE),
    .IW (RS_INDEX_WIDTH)
  ) u_pick (
    .ready      (ready_vec),
    .pick_valid (issue_valid_o),
    .pick_index (issue_index_o)
  );

  assign fire = issue_valid_o & issue_ready_i;

  always_comb begin
    issue_payload_o = '0;
    for (int k = 0; k < 2; k++) begin
      issue_payload_o[k] = entry_q[issue_index_o[k]].payload;
    end
  end

  // Wakeup applies to resident entries; a fresh write sees the same-cycle
  // broadcast through the bypass OR so it never misses a tag.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entry_d[i]          = entry_q[i];
      entry_d[i].src1_rdy = entry_q[i].src1_rdy |
                            tag_hit(wb_valid_i, wb_tag_i, entry_q[i].src1_tag);
      entry_d[i].src2_rdy = entry_q[i].src2_rdy |
                            tag_hit(wb_valid_i, wb_tag_i, entry_q[i].src2_tag);
      for (int p = 0; p < 2; p++) begin
        if (wr_valid_i[p] && (wr_index_i[p] == RS_INDEX_WIDTH'(i))) begin
          entry_d[i]          = wr_entry_i[p];
          entry_d[i].src1_rdy = wr_entry_i[p].src1_rdy |
                                tag_hit(wb_valid_i, wb_tag_i, wr_entry_i[p].src1_tag);
          entry_d[i].src2_rdy = wr_entry_i[p].src2_rdy |
                                tag_hit(wb_valid_i, wb_tag_i, wr_entry_i[p].src2_tag);
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 2; k++) begin
      if (fire[k]) valid_d[issue_index_o[k]] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (wr_valid_i[p]) valid_d[wr_index_i[p]] = 1'b1;
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload and tags carry no reset; valid alone defines occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

  assign rs_unused_o = ~valid_q;
  assign rs_empty_o  = &rs_unused_o;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_valid_i[p]) assert (!valid_q[wr_index_i[p]]);
      end
      if (&wr_valid_i) assert (wr_index_i[0] != wr_index_i[1]);
    end
  end

endmodule

// File: tb/tb_rs_issue2.sv
// Bench for rs_issue2: directed stimulus, expected issues queued per port and
// checked by a monitor at each handshake; occupancy checked inline.
module tb_rs_issue2;
  import rs_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush_i;
  logic [1:0]          wr_valid_i;
  logic [1:0][1:0]     wr_index_i;
  rs_entry_t [1:0]     wr_entry_i;
  logic [1:0]          wb_valid_i;
  logic [1:0][5:0]     wb_tag_i;
  logic [1:0]          issue_valid_o;
  logic [1:0]          issue_ready_i;
  logic [1:0][31:0]    issue_payload_o;
  logic [1:0][1:0]     issue_index_o;
  logic [3:0]          rs_unused_o;
  logic                rs_empty_o;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] pl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rs_issue2 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .wr_valid_i      (wr_valid_i),
    .wr_index_i      (wr_index_i),
    .wr_entry_i      (wr_entry_i),
    .wb_valid_i      (wb_valid_i),
    .wb_tag_i        (wb_tag_i),
    .issue_valid_o   (issue_valid_o),
    .issue_ready_i   (issue_ready_i),
    .issue_payload_o (issue_payload_o),
    .issue_index_o   (issue_index_o),
    .rs_unused_o     (rs_unused_o),
    .rs_empty_o      (rs_empty_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input int idx, input logic [31:0] pl,
                        input logic [5:0] t1, input logic r1,
                        input logic [5:0] t2, input logic r2);
    wr_valid_i[p] = 1'b1;
    wr_index_i[p] = 2'(idx);
    wr_entry_i[p] = '{payload: pl, src1_tag: t1, src1_rdy: r1, src2_tag: t2, src2_rdy: r2};
  endtask

  // Monitor: every accepted handshake must match the head of its port queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush_i) begin
        if (issue_valid_o[0] && issue_ready_i[0]) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL fire0_unexpected: got index %0d, expected no fire", issue_index_o[0]);
          end else begin
            e = q0.pop_front();
            check("fire0_index", 32'(issue_index_o[0]), 32'(e.idx));
            check("fire0_payload", issue_payload_o[0], e.pl);
          end
        end
        if (issue_valid_o[1] && issue_ready_i[1]) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL fire1_unexpected: got index %0d, expected no fire", issue_index_o[1]);
          end else begin
            e = q1.pop_front();
            check("fire1_index", 32'(issue_index_o[1]), 32'(e.idx));
            check("fire1_payload", issue_payload_o[1], e.pl);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; wr_valid_i = '0; wr_index_i = '0; wr_entry_i = '0;
    wb_valid_i = '0; wb_tag_i = '0; issue_ready_i = '0;
    tick(); tick();
    rst_n = 1'b1;

    // reset then idle
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_unused", 32'(rs_unused_o), 32'hF);
      check("idle_empty", 32'(rs_empty_o), 32'h1);
      check("idle_issue_valid", 32'(issue_valid_o), 32'h0);
    end

    // single ready entry goes to port 0; wakeup releases the second
    set_wr(0, 2, 32'hA000_0002, 6'd1, 1'b1, 6'd2, 1'b1);
    set_wr(1, 0, 32'hA000_0000, 6'd5, 1'b0, 6'd3, 1'b1);
    issue_ready_i = 2'b11;
    q0.push_back('{2'd2, 32'hA000_0002});
    tick();
    wr_valid_i = '0;
    check("t2_valid", 32'(issue_valid_o), 32'h1);
    check("t2_idx0", 32'(issue_index_o[0]), 32'h2);
    check("t2_unused", 32'(rs_unused_o), 32'hA);
    wb_valid_i = 2'b01; wb_tag_i[0] = 6'd5;
    q0.push_back('{2'd0, 32'hA000_0000});
    tick();
    wb_valid_i = '0;
    check("t2_wake_valid", 32'(issue_valid_o), 32'h1);
    check("t2_wake_idx0", 32'(issue_index_o[0]), 32'h0);
    check("t2_wake_unused", 32'(rs_unused_o), 32'hE);
    tick();
    check("t2_done_unused", 32'(rs_unused_o), 32'hF);
    check("t2_done_empty", 32'(rs_empty_o), 32'h1);
    check("t2_done_valid", 32'(issue_valid_o), 32'h0);
    issue_ready_i = '0;

    // fill all four; port 1 drains while port 0 stalls
    set_wr(0, 0, 32'hB000_0000, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 1, 32'hB000_0001, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    set_wr(0, 2, 32'hB000_0002, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 3, 32'hB000_0003, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    wr_valid_i = '0;
    check("t3_full_valid", 32'(issue_valid_o), 32'h3);
    check("t3_full_idx0", 32'(issue_index_o[0]), 32'h0);
    check("t3_full_idx1", 32'(issue_index_o[1]), 32'h1);
    check("t3_full_unused", 32'(rs_unused_o), 32'h0);
    check("t3_full_empty", 32'(rs_empty_o), 32'h0);
    issue_ready_i = 2'b10;
    q1.push_back('{2'd1, 32'hB000_0001});
    q1.push_back('{2'd2, 32'hB000_0002});
    q1.push_back('{2'd3, 32'hB000_0003});
    tick();
    check("t3_hold_idx0", 32'(issue_index_o[0]), 32'h0);
    check("t3_next_idx1", 32'(issue_index_o[1]), 32'h2);
    tick();
    check("t3_next2_idx1", 32'(issue_index_o[1]), 32'h3);
    tick();
    check("t3_single_valid", 32'(issue_valid_o), 32'h1);
    check("t3_single_idx0", 32'(issue_index_o[0]), 32'h0);
    check("t3_single_unused", 32'(rs_unused_o), 32'hE);
    issue_ready_i = 2'b01;
    q0.push_back('{2'd0, 32'hB000_0000});
    tick();
    issue_ready_i = '0;
    check("t3_drained_unused", 32'(rs_unused_o), 32'hF);

    // write/wakeup bypass; a tag on an invalid bus must not wake
    set_wr(0, 1, 32'hC000_0001, 6'd4, 1'b1, 6'd9, 1'b0);
    set_wr(1, 2, 32'hC000_0002, 6'd7, 1'b0, 6'd8, 1'b1);
    wb_valid_i = 2'b10; wb_tag_i[1] = 6'd9; wb_tag_i[0] = 6'd7;
    tick();
    wr_valid_i = '0; wb_valid_i = '0;
    check("t4_bypass_valid", 32'(issue_valid_o), 32'h1);
    check("t4_bypass_idx0", 32'(issue_index_o[0]), 32'h1);
    check("t4_bypass_unused", 32'(rs_unused_o), 32'h9);
    issue_ready_i = 2'b01;
    q0.push_back('{2'd1, 32'hC000_0001});
    tick();
    issue_ready_i = '0;
    check("t4_waiting_valid", 32'(issue_valid_o), 32'h0);
    check("t4_waiting_unused", 32'(rs_unused_o), 32'hB);
    wb_valid_i = 2'b01; wb_tag_i[0] = 6'd7;
    tick();
    wb_valid_i = '0;
    check("t4_woken_valid", 32'(issue_valid_o), 32'h1);
    check("t4_woken_idx0", 32'(issue_index_o[0]), 32'h2);
    issue_ready_i = 2'b01;
    q0.push_back('{2'd2, 32'hC000_0002});
    tick();
    issue_ready_i = '0;
    check("t4_done_unused", 32'(rs_unused_o), 32'hF);

    // flush beats a same-cycle write and pending fires
    set_wr(0, 0, 32'hD000_0000, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 1, 32'hD000_0001, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    wr_valid_i = '0;
    set_wr(1, 2, 32'hD000_0002, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    wr_valid_i = '0;
    check("t5_three_unused", 32'(rs_unused_o), 32'h8);
    check("t5_three_valid", 32'(issue_valid_o), 32'h3);
    set_wr(0, 3, 32'hD000_0003, 6'd0, 1'b1, 6'd0, 1'b1);
    flush_i = 1'b1; issue_ready_i = 2'b11;
    tick();
    flush_i = 1'b0; wr_valid_i = '0; issue_ready_i = '0;
    check("t5_flush_unused", 32'(rs_unused_o), 32'hF);
    check("t5_flush_valid", 32'(issue_valid_o), 32'h0);
    check("t5_flush_empty", 32'(rs_empty_o), 32'h1);

    // reset mid-operation overrides fires
    set_wr(0, 0, 32'hE000_0000, 6'd0, 1'b1, 6'd0, 1'b1);
    set_wr(1, 1, 32'hE000_0001, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    wr_valid_i = '0;
    check("t6_pre_valid", 32'(issue_valid_o), 32'h3);
    rst_n = 1'b0; issue_ready_i = 2'b11;
    tick();
    rst_n = 1'b1;
    check("t6_rst_unused", 32'(rs_unused_o), 32'hF);
    check("t6_rst_empty", 32'(rs_empty_o), 32'h1);
    check("t6_rst_valid", 32'(issue_valid_o), 32'h0);
    tick();
    issue_ready_i = '0;
    check("t6_post_valid", 32'(issue_valid_o), 32'h0);

    tick();
    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
